// File: rtl/cache_pkg.sv
// Shared types and geometry helpers for the write-back data cache.
// Imported by cache_line_store and cache_wb_ctrl.
package cache_pkg;

   typedef enum logic [1:0] {
      IDLE,
      WRITEBACK,
      REFILL,
      RESPOND
   } state_t;

   function automatic int off_w(input int words);
      return $clog2(words);
   endfunction

   function automatic int idx_w(input int lines);
      return $clog2(lines);
   endfunction

   function automatic int tag_w(input int addr_w, input int lines,
                                input int words);
      return addr_w - $clog2(lines) - $clog2(words);
   endfunction

endpackage

// File: rtl/cache_line_store.sv
// Data, tag, valid and dirty arrays of the direct-mapped cache.
// Ports: clk/rst, async read port (rd_*), word write port (wr_*) with tag/valid and dirty strobes.
module cache_line_store
   import cache_pkg::*;
#(
   parameter int DATA_W = 32,
   parameter int LINES  = 32,
   parameter int WORDS  = 4,
   parameter int TAG_W  = 3
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic [idx_w(LINES)-1:0]   rd_idx,
   input  logic [off_w(WORDS)-1:0]   rd_off,
   output logic [DATA_W-1:0]         rd_data,
   output logic [TAG_W-1:0]          rd_tag,
   output logic                      rd_valid,
   output logic                      rd_dirty,
   input  logic                      wr_en,
   input  logic [idx_w(LINES)-1:0]   wr_idx,
   input  logic [off_w(WORDS)-1:0]   wr_off,
   input  logic [DATA_W-1:0]         wr_data,
   input  logic [TAG_W-1:0]          wr_tag,
   input  logic                      tag_we,
   input  logic                      dirty_set
);

   logic [DATA_W-1:0] data_mem [LINES][WORDS];
   logic [TAG_W-1:0]  tag_mem  [LINES];
   logic [LINES-1:0]  valid;
   logic [LINES-1:0]  dirty;

   assign rd_data  = data_mem[rd_idx][rd_off];
   assign rd_tag   = tag_mem[rd_idx];
   assign rd_valid = valid[rd_idx];
   assign rd_dirty = dirty[rd_idx];

   // Data and tags are never cleared; only valid/dirty reset.
   always_ff @(posedge clk) begin
      if (wr_en)
         data_mem[wr_idx][wr_off] <= wr_data;
      if (tag_we)
         tag_mem[wr_idx] <= wr_tag;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         valid <= '0;
         dirty <= '0;
      end else begin
         if (tag_we) begin
            valid[wr_idx] <= 1'b1;
            dirty[wr_idx] <= 1'b0;
         end
         if (dirty_set)
            dirty[wr_idx] <= 1'b1;
      end
   end

endmodule

// File: rtl/cache_wb_ctrl.sv
// Direct-mapped write-back, write-allocate cache controller with fill sequencer.
// Ports: cpu_* load/store port (0-cycle hits), mem_* word-transfer port with req/ack.
module cache_wb_ctrl
   import cache_pkg::*;
#(
   parameter int DATA_W = 32,
   parameter int ADDR_W = 10,
   parameter int LINES  = 32,
   parameter int WORDS  = 4
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              cpu_req,
   input  logic              cpu_we,
   input  logic [ADDR_W-1:0] cpu_addr,
   input  logic [DATA_W-1:0] cpu_wdata,
   output logic              cpu_ready,
   output logic [DATA_W-1:0] cpu_rdata,
   output logic              mem_req,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic [DATA_W-1:0] mem_rdata,
   input  logic              mem_ack
);

   localparam int OFF_W = off_w(WORDS);
   localparam int IDX_W = idx_w(LINES);
   localparam int TAG_W = tag_w(ADDR_W, LINES, WORDS);

   state_t           state;
   logic [OFF_W-1:0] wcnt;
   logic [TAG_W-1:0] miss_tag;
   logic [IDX_W-1:0] miss_idx;

   logic [OFF_W-1:0]  cpu_off;
   logic [IDX_W-1:0]  cpu_idx;
   logic [TAG_W-1:0]  cpu_tag;
   logic              serve;
   logic [IDX_W-1:0]  line_idx;
   logic [OFF_W-1:0]  rd_off;
   logic [DATA_W-1:0] rd_data;
   logic [TAG_W-1:0]  rd_tag;
   logic              rd_valid;
   logic              rd_dirty;
   logic              hit;
   logic              last;
   logic              in_wb;
   logic              in_rf;
   logic              fill_we;
   logic              wr_en;
   logic [OFF_W-1:0]  wr_off;
   logic [DATA_W-1:0] wr_data;
   logic              tag_we;
   logic              dirty_set;

   assign cpu_off = cpu_addr[OFF_W-1:0];
   assign cpu_idx = cpu_addr[OFF_W +: IDX_W];
   assign cpu_tag = cpu_addr[ADDR_W-1 -: TAG_W];

   // The miss address is latched so a fill finishes coherently
   // even if the core misbehaves and drops its request.
   assign serve    = (state == IDLE) || (state == RESPOND);
   assign line_idx = serve ? cpu_idx : miss_idx;
   assign rd_off   = serve ? cpu_off : wcnt;

   assign hit  = cpu_req && rd_valid && (rd_tag == cpu_tag);
   assign last = (wcnt == OFF_W'(WORDS - 1));

   assign in_wb = !rst && (state == WRITEBACK);
   assign in_rf = !rst && (state == REFILL);

   assign cpu_ready = !rst && serve && hit;
   assign cpu_rdata = (cpu_ready && !cpu_we) ? rd_data : '0;

   assign fill_we   = in_rf && mem_ack;
   assign dirty_set = cpu_ready && cpu_we;
   assign wr_en     = fill_we || dirty_set;
   assign wr_off    = fill_we ? wcnt : cpu_off;
   assign wr_data   = fill_we ? mem_rdata : cpu_wdata;
   assign tag_we    = fill_we && last;

   assign mem_req   = in_wb || in_rf;
   assign mem_we    = in_wb;
   assign mem_addr  = in_wb ? {rd_tag, miss_idx, wcnt} :
                      in_rf ? {miss_tag, miss_idx, wcnt} : '0;
   assign mem_wdata = in_wb ? rd_data : '0;

   cache_line_store #(
      .DATA_W (DATA_W),
      .LINES  (LINES),
      .WORDS  (WORDS),
      .TAG_W  (TAG_W)
   ) u_store (
      .clk       (clk),
      .rst       (rst),
      .rd_idx    (line_idx),
      .rd_off    (rd_off),
      .rd_data   (rd_data),
      .rd_tag    (rd_tag),
      .rd_valid  (rd_valid),
      .rd_dirty  (rd_dirty),
      .wr_en     (wr_en),
      .wr_idx    (line_idx),
      .wr_off    (wr_off),
      .wr_data   (wr_data),
      .wr_tag    (miss_tag),
      .tag_we    (tag_we),
      .dirty_set (dirty_set)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
         wcnt  <= '0;
      end else begin
         unique case (state)
            IDLE: begin
               if (cpu_req && !hit) begin
                  miss_tag <= cpu_tag;
                  miss_idx <= cpu_idx;
                  wcnt     <= '0;
                  state    <= (rd_valid && rd_dirty) ? WRITEBACK : REFILL;
               end
            end
            WRITEBACK: begin
               if (mem_ack) begin
                  wcnt <= wcnt + 1'b1;
                  if (last)
                     state <= REFILL;
               end
            end
            REFILL: begin
               if (mem_ack) begin
                  wcnt <= wcnt + 1'b1;
                  if (last)
                     state <= RESPOND;
               end
            end
            RESPOND: state <= IDLE;
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_cache_wb_ctrl.sv
// Self-checking bench for cache_wb_ctrl: directed scenarios plus random
// accesses against a flat-memory view of what the core should observe.
module tb_cache_wb_ctrl;

   logic        clk = 1'b0;
   logic        rst;
   logic        cpu_req;
   logic        cpu_we;
   logic [9:0]  cpu_addr;
   logic [31:0] cpu_wdata;
   logic        cpu_ready;
   logic [31:0] cpu_rdata;
   logic        mem_req;
   logic        mem_we;
   logic [9:0]  mem_addr;
   logic [31:0] mem_wdata;
   logic [31:0] mem_rdata;
   logic        mem_ack;

   int checks = 0;
   int errors = 0;

   // Main memory contents and the value the core must see per address.
   logic [31:0] mem    [1024];
   logic [31:0] shadow [1024];
   // Which block each line holds, per the cache's replacement rules.
   bit          lv [32];
   bit          ld [32];
   logic [2:0]  lt [32];

   cache_wb_ctrl dut (
      .clk       (clk),
      .rst       (rst),
      .cpu_req   (cpu_req),
      .cpu_we    (cpu_we),
      .cpu_addr  (cpu_addr),
      .cpu_wdata (cpu_wdata),
      .cpu_ready (cpu_ready),
      .cpu_rdata (cpu_rdata),
      .mem_req   (mem_req),
      .mem_we    (mem_we),
      .mem_addr  (mem_addr),
      .mem_wdata (mem_wdata),
      .mem_rdata (mem_rdata),
      .mem_ack   (mem_ack)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] obs,
                      input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      for (int i = 0; i < 32; i++) begin
         lv[i] = 0;
         ld[i] = 0;
      end
      // Dirty data is lost; the core now sees main memory again.
      for (int i = 0; i < 1024; i++) shadow[i] = mem[i];
   endtask

   // Called at posedge+1. mode: 0 ack high, 1 ack every third cycle,
   // 2 random ack. exp_lat < 0 means derive latency from transfers+waits.
   task automatic do_access(input logic we, input logic [9:0] a,
                            input logic [31:0] wd, input int mode,
                            input int exp_lat, output logic [31:0] rd);
      logic [2:0] tg;
      logic [4:0] idx;
      logic [9:0] qa[$];
      bit         qw[$];
      bit         hit;
      bit         done;
      int         c;
      int         waits;
      int         lat;
      int         nx;
      int         exp;
      tg    = a[9:7];
      idx   = a[6:2];
      hit   = lv[idx] && (lt[idx] == tg);
      done  = 0;
      c     = 0;
      waits = 0;
      lat   = -1;
      rd    = '0;
      if (!hit) begin
         if (lv[idx] && ld[idx])
            for (int k = 0; k < 4; k++) begin
               qa.push_back({lt[idx], idx, 2'(k)});
               qw.push_back(1'b1);
            end
         for (int k = 0; k < 4; k++) begin
            qa.push_back({tg, idx, 2'(k)});
            qw.push_back(1'b0);
         end
      end
      nx = qa.size();
      cpu_req   = 1'b1;
      cpu_we    = we;
      cpu_addr  = a;
      cpu_wdata = wd;
      while (!done && c < 200) begin
         #1;
         case (mode)
            0:       mem_ack = 1'b1;
            1:       mem_ack = (c % 3 == 0);
            default: mem_ack = 1'($urandom_range(0, 1));
         endcase
         mem_rdata = (mem_req && !mem_we) ? mem[mem_addr] : $urandom;
         #1;
         if (c == 0) begin
            chk("idle_mem_req", mem_req, 0);
            chk("hit_ready", cpu_ready, hit);
            if (!cpu_ready) chk("miss_rdata_zero", cpu_rdata, 0);
         end
         if (mem_req && mem_ack) begin
            if (qa.size() == 0) chk("extra_xfer", 1, 0);
            else begin
               chk("xfer_we", mem_we, qw[0]);
               chk("xfer_addr", mem_addr, qa[0]);
               if (mem_we) begin
                  chk("wb_data", mem_wdata, shadow[mem_addr]);
                  mem[mem_addr] = mem_wdata;
               end
               void'(qa.pop_front());
               void'(qw.pop_front());
            end
         end else if (mem_req) waits++;
         if (cpu_ready) begin
            done = 1;
            lat  = c;
            rd   = cpu_rdata;
         end
         @(posedge clk);
         #1;
         c++;
      end
      cpu_req = 1'b0;
      mem_ack = 1'b0;
      chk("access_done", done, 1);
      chk("xfers_left", qa.size(), 0);
      exp = (exp_lat >= 0) ? exp_lat : (hit ? 0 : nx + waits + 1);
      chk("latency", lat, exp);
      if (!we) chk("load_data", rd, shadow[a]);
      ld[idx] = hit ? (ld[idx] | we) : we;
      lv[idx] = 1;
      lt[idx] = tg;
      if (we) shadow[a] = wd;
   endtask

   initial begin
      logic [31:0] rd;
      logic [9:0]  ra;
      rst       = 1'b1;
      cpu_req   = 1'b0;
      cpu_we    = 1'b0;
      cpu_addr  = '0;
      cpu_wdata = '0;
      mem_rdata = '0;
      mem_ack   = 1'b0;
      for (int i = 0; i < 1024; i++) mem[i] = $urandom;
      for (int i = 0; i < 4; i++) mem[i] = 32'hA0 + 32'(i);
      model_reset();

      repeat (2) @(posedge clk);
      #1;
      cpu_req = 1'b1;
      mem_ack = 1'b1;
      #2;
      chk("rst_cpu_ready", cpu_ready, 0);
      chk("rst_cpu_rdata", cpu_rdata, 0);
      chk("rst_mem_req", mem_req, 0);
      chk("rst_mem_we", mem_we, 0);
      chk("rst_mem_addr", mem_addr, 0);
      chk("rst_mem_wdata", mem_wdata, 0);
      @(posedge clk);
      #1;
      rst     = 1'b0;
      cpu_req = 1'b0;
      mem_ack = 1'b0;
      #1;
      chk("post_rst_mem_req", mem_req, 0);
      chk("post_rst_ready", cpu_ready, 0);
      @(posedge clk);
      #1;

      do_access(1'b0, 10'h000, 0, 0, 5, rd);
      chk("cold_rdata", rd, 32'hA0);
      do_access(1'b0, 10'h002, 0, 0, 0, rd);
      chk("hit_rdata", rd, 32'hA2);
      do_access(1'b1, 10'h001, 32'h55, 0, 0, rd);
      do_access(1'b0, 10'h081, 0, 0, 9, rd);
      chk("evicted_word1", mem[10'h001], 32'h55);
      do_access(1'b1, 10'h104, 32'h77, 0, 5, rd);
      do_access(1'b0, 10'h104, 0, 0, 0, rd);
      chk("alloc_rdata", rd, 32'h77);
      do_access(1'b0, 10'h208, 0, 1, 13, rd);

      cpu_req  = 1'b1;
      cpu_we   = 1'b0;
      cpu_addr = 10'h30C;
      for (int c = 0; c < 3; c++) begin
         #1;
         mem_ack   = 1'b1;
         mem_rdata = mem[mem_addr];
         @(posedge clk);
         #1;
      end
      rst     = 1'b1;
      cpu_req = 1'b0;
      mem_ack = 1'b0;
      #2;
      chk("midfill_rst_mem_req", mem_req, 0);
      chk("midfill_rst_ready", cpu_ready, 0);
      @(posedge clk);
      #1;
      rst = 1'b0;
      #1;
      chk("after_abort_mem_req", mem_req, 0);
      @(posedge clk);
      #1;
      model_reset();
      do_access(1'b0, 10'h30C, 0, 0, 5, rd);

      for (int n = 0; n < 250; n++) begin
         ra = {3'($urandom_range(0, 7)), 5'($urandom_range(0, 3)),
               2'($urandom_range(0, 3))};
         do_access(1'($urandom_range(0, 1)), ra, $urandom,
                   (n % 5 == 0) ? 0 : 2, -1, rd);
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
